bcd_display_decoder: RTL and testbench

- Consumer end of the keypad path: takes the 4-bit BCD code and key-pressed flag from the keypad encoder.
- Captures one digit per key press into a DIGITS-deep entry register, most recent digit in position 0.
- Decodes stored digits to 7-segment patterns and time-multiplexes them onto a common-cathode display.
- Also exposes the raw entered code and digit count to the lock controller.

---
 rtl/lock_pkg.sv | 31 +++
 rtl/bcd_display_decoder_seg.sv | 33 +++
 rtl/bcd_display_decoder.sv | 145 ++++++++++++++
 tb/tb_bcd_display_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the keypad / lock datapath:
//   - 7-segment patterns (active-high, bit0=a ... bit6=g) for digits 0..9
//   - SEG_BLANK for unused or invalid positions
//   - BCD_MAX, the largest digit code accepted from the keypad
//   - DIGITS_DEFAULT, the default entry length / display width
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int         DIGITS_DEFAULT = 4;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when the code is a decimal digit the entry register may accept.
  function automatic logic bcd_valid(input logic [3:0] code);
    return (code <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_display_decoder_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Purely combinational BCD digit to 7-segment pattern decoder.
// Ports:
//   code    in  4  BCD digit
//   pattern out 7  active-high segments, bit0=a ... bit6=g; blank for codes >= 10
// -----------------------------------------------------------------------------
module bcd_to_7seg
  import lock_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Digit-to-segment lookup; anything outside 0..9 is shown blank.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_decoder.sv
// -----------------------------------------------------------------------------
// bcd_display_decoder
// Captures one BCD digit per key press into a DIGITS-deep shift register
// (newest digit in position 0), exposes the entered code to the lock
// controller, and time-multiplexes the digits onto a common-cathode display.
// Ports:
//   clk            in  1                 system clock, rising edge
//   rst            in  1                 synchronous active-high reset
//   BCD            in  4                 digit code, valid while tecla_acionada=1
//   tecla_acionada in  1                 key-pressed level
//   clear          in  1                 synchronous clear of the entered code
//   digits_out     out 4*DIGITS          entered code, [3:0] = newest digit
//   count          out clog2(DIGITS+1)   number of digits entered
//   full           out 1                 count == DIGITS
//   seg            out 7                 segments, active-high, seg[0]=a
//   an             out DIGITS            one-hot active position
// -----------------------------------------------------------------------------
module bcd_display_decoder
  import lock_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEFAULT,
  parameter int SCAN_DIV = 1000
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   BCD,
  input  logic                         tecla_acionada,
  input  logic                         clear,
  output logic [4*DIGITS-1:0]          digits_out,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            an
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(SCAN_DIV);

  logic                   key_q, key_d;
  logic [DIGITS-1:0][3:0] digits_q, digits_d;
  logic [CW-1:0]          count_q, count_d;
  logic [TW-1:0]          scan_cnt_q, scan_cnt_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d;

  logic                   press_s;
  logic                   accept_s;
  logic [3:0]             sel_digit_s;
  logic [6:0]             sel_pattern_s;

  // Rising edge of the key level; key_q resets high so a key held through
  // reset is not mistaken for a fresh press.
  assign press_s  = tecla_acionada & ~key_q;
  assign accept_s = press_s & bcd_valid(BCD) & (count_q < CW'(DIGITS));

  // Edge-detect history follows the raw key level every cycle.
  always_comb begin
    key_d = tecla_acionada;
  end

  // Entry register: clear wins over a coincident press; full register holds.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (accept_s) begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        digits_d[i] = digits_q[i-1];
      end
      digits_d[0] = BCD;
      count_d     = count_q + CW'(1);
    end else begin
      digits_d = digits_q;
      count_d  = count_q;
    end
  end

  // Scan timer: each position stays lit for SCAN_DIV cycles, slots wrap.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    slot_d     = slot_q;
    if (scan_cnt_q == TW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      if (slot_q == SW'(DIGITS - 1)) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end else begin
      scan_cnt_d = scan_cnt_q + TW'(1);
      slot_d     = slot_q;
    end
  end

  assign sel_digit_s = digits_q[slot_q];

  bcd_to_7seg u_seg (
    .code    (sel_digit_s),
    .pattern (sel_pattern_s)
  );

  // Display drive: positions beyond the entered count are blanked.
  always_comb begin
    an_d         = '0;
    an_d[slot_q] = 1'b1;
    if (32'(slot_q) < 32'(count_q)) begin
      seg_d = sel_pattern_s;
    end else begin
      seg_d = SEG_BLANK;
    end
  end

  // State and registered display outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= 1'b1;
      digits_q   <= '0;
      count_q    <= '0;
      scan_cnt_q <= '0;
      slot_q     <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= DIGITS'(1);
    end else begin
      key_q      <= key_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      scan_cnt_q <= scan_cnt_d;
      slot_q     <= slot_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign digits_out = digits_q;
  assign count      = count_q;
  assign full       = (count_q == CW'(DIGITS));
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_bcd_display_decoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_decoder
// Directed stimulus with hand-computed expectations pushed to a scoreboard
// queue; a negedge monitor pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_bcd_display_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  BCD;
  logic        tecla_acionada;
  logic        clear;
  logic [15:0] digits_out;
  logic [2:0]  count;
  logic        full;
  logic [6:0]  seg;
  logic [3:0]  an;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    bit          chk_state;
    logic [15:0] digits;
    logic [2:0]  cnt;
    logic        full;
    bit          chk_disp;
    logic [6:0]  seg;
    logic [3:0]  an;
    bit          forced_fail;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  bcd_display_decoder #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .BCD            (BCD),
    .tecla_acionada (tecla_acionada),
    .clear          (clear),
    .digits_out     (digits_out),
    .count          (count),
    .full           (full),
    .seg            (seg),
    .an             (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Monitor: compares every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.forced_fail) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s: bound expired", mon_e.name);
      end
      if (mon_e.chk_state) begin
        tests_run++;
        if (digits_out !== mon_e.digits || count !== mon_e.cnt || full !== mon_e.full) begin
          tests_failed++;
          $display("FAIL %s: got digits=%h count=%0d full=%b, expected digits=%h count=%0d full=%b",
                   mon_e.name, digits_out, count, full, mon_e.digits, mon_e.cnt, mon_e.full);
        end
      end
      if (mon_e.chk_disp) begin
        tests_run++;
        if (seg !== mon_e.seg || an !== mon_e.an) begin
          tests_failed++;
          $display("FAIL %s: got seg=%h an=%b, expected seg=%h an=%b",
                   mon_e.name, seg, an, mon_e.seg, mon_e.an);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_state(input string n, input logic [15:0] d, input logic [2:0] c, input logic f);
    exp_t e;
    e = '{name: n, chk_state: 1'b1, digits: d, cnt: c, full: f,
          chk_disp: 1'b0, seg: 7'h00, an: 4'h0, forced_fail: 1'b0};
    sb_q.push_back(e);
  endtask

  task automatic exp_both(input string n, input logic [15:0] d, input logic [2:0] c, input logic f,
                          input logic [6:0] s, input logic [3:0] a);
    exp_t e;
    e = '{name: n, chk_state: 1'b1, digits: d, cnt: c, full: f,
          chk_disp: 1'b1, seg: s, an: a, forced_fail: 1'b0};
    sb_q.push_back(e);
  endtask

  task automatic exp_disp(input string n, input logic [6:0] s, input logic [3:0] a);
    exp_t e;
    e = '{name: n, chk_state: 1'b0, digits: 16'h0, cnt: 3'd0, full: 1'b0,
          chk_disp: 1'b1, seg: s, an: a, forced_fail: 1'b0};
    sb_q.push_back(e);
  endtask

  task automatic exp_timeout(input string n);
    exp_t e;
    e = '{name: n, chk_state: 1'b0, digits: 16'h0, cnt: 3'd0, full: 1'b0,
          chk_disp: 1'b0, seg: 7'h00, an: 4'h0, forced_fail: 1'b1};
    sb_q.push_back(e);
  endtask

  // One key press: 3 cycles held, 2 cycles released.
  task automatic press(input logic [3:0] code);
    BCD            = code;
    tecla_acionada = 1'b1;
    repeat (3) step();
    tecla_acionada = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    logic [3:0]  an_tab [4];
    logic [6:0]  seg_tab [4];
    int          bound;
    an_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seg_tab = '{7'h7F, 7'h06, 7'h00, 7'h00};

    rst            = 1'b1;
    BCD            = 4'd0;
    tecla_acionada = 1'b1;
    clear          = 1'b0;

    // Reset with key held, then free-running scan with no entries.
    repeat (2) step();
    rst = 1'b0;
    exp_both("reset", 16'h0000, 3'd0, 1'b0, 7'h00, 4'b0001);
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_both($sformatf("scan_k%0d", k), 16'h0000, 3'd0, 1'b0, 7'h00, an_tab[((k - 1) / 4) % 4]);
      if (k == 2) tecla_acionada = 1'b0;
    end

    // Four entries fill the register; a fifth is discarded.
    press(4'd1); exp_state("entry_1", 16'h0001, 3'd1, 1'b0);
    press(4'd2); exp_state("entry_2", 16'h0012, 3'd2, 1'b0);
    press(4'd3); exp_state("entry_3", 16'h0123, 3'd3, 1'b0);
    press(4'd4); exp_state("entry_4", 16'h1234, 3'd4, 1'b1);
    press(4'd7); exp_state("entry_full", 16'h1234, 3'd4, 1'b1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_state("clear", 16'h0000, 3'd0, 1'b0);

    // Held key produces exactly one entry.
    BCD            = 4'd5;
    tecla_acionada = 1'b1;
    repeat (25) step();
    exp_state("held_mid", 16'h0005, 3'd1, 1'b0);
    repeat (25) step();
    exp_state("held_end", 16'h0005, 3'd1, 1'b0);
    tecla_acionada = 1'b0;
    repeat (2) step();

    press(4'hA); exp_state("invalid_A", 16'h0005, 3'd1, 1'b0);
    press(4'hF); exp_state("invalid_F", 16'h0005, 3'd1, 1'b0);
    press(4'd3); exp_state("second_entry", 16'h0053, 3'd2, 1'b0);

    // Clear coincident with a press: press is lost.
    BCD            = 4'd9;
    tecla_acionada = 1'b1;
    clear          = 1'b1;
    step();
    clear = 1'b0;
    exp_state("clear_collision", 16'h0000, 3'd0, 1'b0);
    repeat (2) step();
    exp_state("collision_held", 16'h0000, 3'd0, 1'b0);
    tecla_acionada = 1'b0;
    repeat (2) step();

    // Display content with digits 1 then 8.
    press(4'd1);
    press(4'd8);
    exp_state("disp_entry", 16'h0018, 3'd2, 1'b0);
    bound = 0;
    while (an == 4'b0001 && bound < 20) begin step(); bound++; end
    while (an != 4'b0001 && bound < 40) begin step(); bound++; end
    if (an != 4'b0001) begin
      exp_timeout("scan_sync");
    end else begin
      for (int s = 0; s < 16; s++) begin
        exp_disp($sformatf("disp_s%0d", s), seg_tab[s / 4], an_tab[s / 4]);
        step();
      end
    end

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
